// File: rtl/card_dealer.sv
// Card dealer: draws four cards from a free-running random nibble,
// rejecting out-of-range samples with a bounded-retry fallback.
module card_dealer #(
  parameter int unsigned SKIP      = 4,
  parameter int unsigned MIN_VAL   = 1,
  parameter int unsigned MAX_VAL   = 9,
  parameter int unsigned MAX_TRIES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rand_in,
  input  logic       deal_req,
  output logic [3:0] card0,
  output logic [3:0] card1,
  output logic [3:0] card2,
  output logic [3:0] card3,
  output logic       busy,
  output logic       valid
);

  localparam logic [3:0] SKIP_LAST = 4'(SKIP - 1);
  localparam logic [7:0] TRY_LAST  = 8'(MAX_TRIES - 1);
  localparam logic [3:0] LO        = 4'(MIN_VAL);
  localparam logic [3:0] HI        = 4'(MAX_VAL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEAL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [1:0] idx, idx_n;
  logic [3:0] skip_cnt, skip_n;
  logic [7:0] try_cnt, try_n;
  logic [3:0] cards [4];
  logic [3:0] cards_n [4];
  logic       in_range;
  logic       load;

  assign in_range = (rand_in >= LO) && (rand_in <= HI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      skip_cnt <= '0;
      try_cnt  <= '0;
      for (int i = 0; i < 4; i++) cards[i] <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      skip_cnt <= skip_n;
      try_cnt  <= try_n;
      for (int i = 0; i < 4; i++) cards[i] <= cards_n[i];
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    skip_n  = skip_cnt;
    try_n   = try_cnt;
    load    = 1'b0;
    for (int i = 0; i < 4; i++) cards_n[i] = cards[i];
    unique case (state)
      IDLE, DONE: begin
        if (deal_req) begin
          state_n = DEAL;
          idx_n   = '0;
          skip_n  = '0;
          try_n   = '0;
        end
      end
      DEAL: begin
        if (skip_cnt == SKIP_LAST) begin
          skip_n = '0;
          if (in_range) begin
            cards_n[idx] = rand_in;
            load         = 1'b1;
          end else if (try_cnt == TRY_LAST) begin
            // out of retries: fall back to the lowest legal value
            cards_n[idx] = LO;
            load         = 1'b1;
          end else begin
            try_n = try_cnt + 8'd1;
          end
          if (load) begin
            try_n = '0;
            idx_n = idx + 2'd1;
            if (idx == 2'd3) state_n = DONE;
          end
        end else begin
          skip_n = skip_cnt + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign card0 = cards[0];
  assign card1 = cards[1];
  assign card2 = cards[2];
  assign card3 = cards[3];
  assign busy  = (state == DEAL);
  assign valid = (state == DONE);

endmodule

// File: tb/tb_card_dealer.sv
// Randomized bench for card_dealer: two instances (SKIP=4, SKIP=1)
// checked against a sample-sequence model of the dealing rules.
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] rand_in;
  logic       deal_req;

  logic [3:0] a0, a1, a2, a3;
  logic       a_busy, a_valid;
  logic [3:0] b0, b1, b2, b3;
  logic       b_busy, b_valid;

  int n_chk  = 0;
  int n_fail = 0;

  int r [0:255];
  int exp_c [2][4];
  int exp_l [2];

  always #5 clk = ~clk;

  card_dealer dut (
    .clk(clk), .rst(rst), .rand_in(rand_in), .deal_req(deal_req),
    .card0(a0), .card1(a1), .card2(a2), .card3(a3),
    .busy(a_busy), .valid(a_valid)
  );

  card_dealer #(.SKIP(1)) dut1 (
    .clk(clk), .rst(rst), .rand_in(rand_in), .deal_req(deal_req),
    .card0(b0), .card1(b1), .card2(b2), .card3(b3),
    .busy(b_busy), .valid(b_valid)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // r[k] is the nibble present at the k-th edge after the request edge
  function automatic void model(input int sel, input int sk);
    int t;
    int tries;
    int v;
    t = 0;
    for (int c = 0; c < 4; c++) begin
      tries = 0;
      while (1) begin
        t += sk;
        v = r[t];
        if (v >= 1 && v <= 9) begin
          exp_c[sel][c] = v;
          break;
        end
        tries++;
        if (tries == 8) begin
          exp_c[sel][c] = 1;
          break;
        end
      end
    end
    exp_l[sel] = t;
  endfunction

  task automatic chk_a(input string tag);
    chk({tag, " a.card0"}, int'(a0), exp_c[0][0]);
    chk({tag, " a.card1"}, int'(a1), exp_c[0][1]);
    chk({tag, " a.card2"}, int'(a2), exp_c[0][2]);
    chk({tag, " a.card3"}, int'(a3), exp_c[0][3]);
  endtask

  task automatic chk_b(input string tag);
    chk({tag, " b.card0"}, int'(b0), exp_c[1][0]);
    chk({tag, " b.card1"}, int'(b1), exp_c[1][1]);
    chk({tag, " b.card2"}, int'(b2), exp_c[1][2]);
    chk({tag, " b.card3"}, int'(b3), exp_c[1][3]);
  endtask

  // hold=1 keeps deal_req high; only the SKIP=4 instance is checked then
  task automatic run_deal(input string tag, input bit hold);
    int mx;
    model(0, 4);
    model(1, 1);
    mx = hold ? exp_l[0] : (exp_l[0] > exp_l[1] ? exp_l[0] : exp_l[1]) + 2;
    @(negedge clk);
    deal_req = 1'b1;
    rand_in  = 4'(r[0]);
    @(negedge clk);
    deal_req = hold;
    for (int k = 1; k <= mx; k++) begin
      rand_in = 4'(r[k]);
      @(negedge clk);
      if (k == exp_l[0] - 1) begin
        chk({tag, " a.busy pre"}, int'(a_busy), 1);
        chk({tag, " a.valid pre"}, int'(a_valid), 0);
      end
      if (k == exp_l[0]) begin
        chk({tag, " a.valid"}, int'(a_valid), 1);
        chk({tag, " a.busy"}, int'(a_busy), 0);
        chk_a(tag);
      end
      if (!hold && k == exp_l[1] - 1)
        chk({tag, " b.valid pre"}, int'(b_valid), 0);
      if (!hold && k == exp_l[1]) begin
        chk({tag, " b.valid"}, int'(b_valid), 1);
        chk_b(tag);
      end
    end
    if (hold) begin
      rand_in = 4'(r[mx + 1]);
      @(negedge clk);
      chk({tag, " a.valid restart"}, int'(a_valid), 0);
      chk({tag, " a.busy restart"}, int'(a_busy), 1);
      deal_req = 1'b0;
    end else begin
      chk({tag, " a.valid hold"}, int'(a_valid), 1);
      chk({tag, " b.valid hold"}, int'(b_valid), 1);
      chk_a({tag, " hold"});
      chk_b({tag, " hold"});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < 256; i++) r[i] = v;
  endtask

  initial begin
    int s;
    int hi;
    rst      = 1'b1;
    deal_req = 1'b0;
    rand_in  = 4'd0;
    #2;
    chk("reset card0", int'(a0), 0);
    chk("reset card3", int'(a3), 0);
    chk("reset busy", int'(a_busy), 0);
    chk("reset valid", int'(a_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("no deal after reset", int'(a_busy), 0);

    fill(5);
    run_deal("held5", 1'b0);
    chk("held5 latency", exp_l[0], 16);
    chk("held5 card", int'(a2), 5);

    fill(12);
    run_deal("held12", 1'b0);
    chk("held12 latency", exp_l[0], 128);
    chk("held12 card", int'(a1), 1);

    for (int i = 0; i < 256; i++) r[i] = $urandom_range(0, 15);
    r[1] = 0; r[2] = 9; r[3] = 10; r[4] = 1;
    r[5] = 15; r[6] = 7; r[7] = 3;
    run_deal("seq", 1'b0);
    chk("seq b.card0", int'(b0), 9);
    chk("seq b.card1", int'(b1), 1);
    chk("seq b.card2", int'(b2), 7);
    chk("seq b.card3", int'(b3), 3);
    chk("seq b.latency", exp_l[1], 7);

    fill(5);
    run_deal("reqheld", 1'b1);
    do_reset();

    @(negedge clk);
    deal_req = 1'b1;
    rand_in  = 4'd5;
    @(negedge clk);
    deal_req = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrst card1 loaded", int'(a1), 5);
    chk("midrst card2 pending", int'(a2), 0);
    rst = 1'b1;
    #1;
    chk("midrst card0", int'(a0), 0);
    chk("midrst card1", int'(a1), 0);
    chk("midrst busy", int'(a_busy), 0);
    chk("midrst valid", int'(a_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) r[i] = $urandom_range(0, 15);
    run_deal("after rst", 1'b0);

    s = 0;
    for (int i = 0; i < 256; i++) begin
      r[i] = s;
      s = ((s << 1) & 14) | (((s >> 3) ^ (s >> 2) ^ 1) & 1);
    end
    run_deal("lfsr", 1'b0);
    chk("lfsr latency bound", int'(exp_l[0] <= 128), 1);
    for (int c = 0; c < 4; c++)
      chk("lfsr card range", int'(exp_c[0][c] >= 1 && exp_c[0][c] <= 9), 1);

    for (int n = 0; n < 8; n++) begin
      hi = (n % 2) ? 15 : 12;
      for (int i = 0; i < 256; i++)
        r[i] = (n % 2) ? $urandom_range(6, hi) : $urandom_range(0, hi);
      run_deal($sformatf("rand%0d", n), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
